// File: rtl/lvdc_pio_initiator.sv
// LVDC PIO read initiator.
// Runs a free-running W/X/Y/Z phase generator. On each accepted request it
// presents a 9-bit PIO address to the LVDA for one bit time, then shifts in
// WORD_BITS serial data bits, MSB first.
// Optional feature: define PIO_PARITY_EN to add one parity bit time with an
// odd-parity check reported on perr.
module lvdc_pio_initiator #(
  parameter int PHASE_LEN = 1,
  parameter int WORD_BITS = 26
) (
  input  logic                 SIM_CLK,
  input  logic                 SIM_RST,
  input  logic                 req,
  input  logic [8:0]           addr,
  output logic                 ready,
  output logic [WORD_BITS-1:0] rdata,
  output logic                 rvalid,
  output logic                 perr,
  output logic                 A1V,
  output logic                 A2V,
  output logic                 A3V,
  output logic                 A4V,
  output logic                 A5V,
  output logic                 A6V,
  output logic                 A7V,
  output logic                 A8V,
  output logic                 A9V,
  output logic                 PIOV,
  output logic                 WDA,
  output logic                 XDA,
  output logic                 YDA,
  output logic                 ZDA,
  input  logic                 DATAV
);

  localparam int BW = $clog2(WORD_BITS + 1);
  localparam logic [3:0]    LAST_CNT = 4'(PHASE_LEN - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);

  typedef enum logic [2:0] {IDLE, SYNC, ADDR, SHIFT, PAR, DONE} state_e;

  state_e               state_q, state_d;
  logic [3:0]           phase_q, phase_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [8:0]           addr_q, addr_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-1:0] rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 rvalid_q, rvalid_d;
  logic                 piov_q, piov_d;
  logic [8:0]           av_q, av_d;
  logic                 phase_last, y_last, z_last;
`ifdef PIO_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 par_q, par_d;
`endif

  assign phase_last = (cnt_q == LAST_CNT);
  assign y_last     = phase_q[2] & phase_last;
  assign z_last     = phase_q[3] & phase_last;

  // Phase rotation W->X->Y->Z; an all-zero phase means W is pending after reset
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (phase_q == 4'b0000) begin
      phase_d = 4'b0001;
      cnt_d   = '0;
    end else if (phase_last) begin
      phase_d = {phase_q[2:0], phase_q[3]};
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Transaction sequencing and serial data capture
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bit_cnt_d = bit_cnt_q;
    rdata_d   = rdata_q;
`ifdef PIO_PARITY_EN
    perr_d    = perr_q;
    par_d     = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SYNC;
          addr_d  = addr;
`ifdef PIO_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      SYNC: begin
        if (z_last) state_d = ADDR;
      end
      ADDR: begin
        if (z_last) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
`ifdef PIO_PARITY_EN
          par_d     = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (y_last) begin
          rdata_d = {rdata_q[WORD_BITS-2:0], DATAV};
`ifdef PIO_PARITY_EN
          par_d   = par_q ^ DATAV;
`endif
        end
        if (z_last) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef PIO_PARITY_EN
            state_d = PAR;
`else
            state_d = DONE;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
`ifdef PIO_PARITY_EN
      PAR: begin
        if (y_last) perr_d = ~(par_q ^ DATAV);
        if (z_last) state_d = DONE;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered LVDA/host outputs decoded from the next state
  always_comb begin
    ready_d  = (state_d == IDLE);
    rvalid_d = (state_d == DONE);
    piov_d   = (state_d == ADDR);
    av_d     = (state_d == ADDR) ? addr_d : 9'd0;
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_q   <= IDLE;
      phase_q   <= 4'b0000;
      cnt_q     <= '0;
      addr_q    <= '0;
      bit_cnt_q <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b1;
      rvalid_q  <= 1'b0;
      piov_q    <= 1'b0;
      av_q      <= '0;
`ifdef PIO_PARITY_EN
      perr_q    <= 1'b0;
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      bit_cnt_q <= bit_cnt_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      rvalid_q  <= rvalid_d;
      piov_q    <= piov_d;
      av_q      <= av_d;
`ifdef PIO_PARITY_EN
      perr_q    <= perr_d;
      par_q     <= par_d;
`endif
    end
  end

  assign ready  = ready_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign PIOV   = piov_q;
  assign {A9V, A8V, A7V, A6V, A5V, A4V, A3V, A2V, A1V} = av_q;
  assign {ZDA, YDA, XDA, WDA} = phase_q;
`ifdef PIO_PARITY_EN
  assign perr   = perr_q;
`else
  assign perr   = 1'b0;
`endif

endmodule

// File: tb/tb_lvdc_pio_initiator.sv
// Testbench for lvdc_pio_initiator: two instances (PHASE_LEN 1 and 3) share
// clock and reset; an LVDA-like driver feeds DATAV and a cycle-indexed model
// predicts phases, strobes, handshake and the returned word.
`timescale 1ns/1ps
module tb_lvdc_pio_initiator;

  localparam int WB = 26;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req, ready, rvalid, perr, piov, datav;
  logic [1:0]    wda, xda, yda, zda;
  logic [8:0]    addr0, addr1, abus0, abus1;
  logic [WB-1:0] rdata0, rdata1;
  int            compared = 0;
  int            mismatched = 0;
  int            cyc = 0;

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle index since reset release: cycle k is the one following the k-th edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  lvdc_pio_initiator #(.PHASE_LEN(1), .WORD_BITS(WB)) dut0 (
    .SIM_CLK(clk), .SIM_RST(rst_n), .req(req[0]), .addr(addr0),
    .ready(ready[0]), .rdata(rdata0), .rvalid(rvalid[0]), .perr(perr[0]),
    .A1V(abus0[0]), .A2V(abus0[1]), .A3V(abus0[2]), .A4V(abus0[3]),
    .A5V(abus0[4]), .A6V(abus0[5]), .A7V(abus0[6]), .A8V(abus0[7]),
    .A9V(abus0[8]), .PIOV(piov[0]), .WDA(wda[0]), .XDA(xda[0]),
    .YDA(yda[0]), .ZDA(zda[0]), .DATAV(datav[0])
  );

  lvdc_pio_initiator #(.PHASE_LEN(3), .WORD_BITS(WB)) dut1 (
    .SIM_CLK(clk), .SIM_RST(rst_n), .req(req[1]), .addr(addr1),
    .ready(ready[1]), .rdata(rdata1), .rvalid(rvalid[1]), .perr(perr[1]),
    .A1V(abus1[0]), .A2V(abus1[1]), .A3V(abus1[2]), .A4V(abus1[3]),
    .A5V(abus1[4]), .A6V(abus1[5]), .A7V(abus1[6]), .A8V(abus1[7]),
    .A9V(abus1[8]), .PIOV(piov[1]), .WDA(wda[1]), .XDA(xda[1]),
    .YDA(yda[1]), .ZDA(zda[1]), .DATAV(datav[1])
  );

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic setAddr(input int s, input logic [8:0] a);
    if (s == 0) addr0 = a;
    else        addr1 = a;
  endtask

  // Phase sequence and idle outputs right after reset release
  task automatic phaseCheck(input int cycles);
    int p, ph;
    logic [3:0] expv, gotv;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        p    = (s == 0) ? 1 : 3;
        ph   = ((cyc - 1) / p) % 4;
        expv = 4'b0001 << ph;
        gotv = {zda[s], yda[s], xda[s], wda[s]};
        checkOutput($sformatf("phase%0d_c%0d", s, cyc), gotv, expv);
        checkOutput($sformatf("idle_rvalid%0d_c%0d", s, cyc), rvalid[s], 1'b0);
      end
    end
  endtask

  // Assert reset now, check reset outputs, release on a falling edge
  task automatic resetPulse();
    rst_n = 1'b0;
    req   = 2'b00;
    #1;
    for (int s = 0; s < 2; s++) begin
      checkOutput($sformatf("rst_ready%0d", s), ready[s], 1'b1);
      checkOutput($sformatf("rst_piov%0d", s), piov[s], 1'b0);
      checkOutput($sformatf("rst_rvalid%0d", s), rvalid[s], 1'b0);
      checkOutput($sformatf("rst_perr%0d", s), perr[s], 1'b0);
      checkOutput($sformatf("rst_phase%0d", s), {zda[s], yda[s], xda[s], wda[s]}, 4'b0000);
      checkOutput($sformatf("rst_abus%0d", s), (s == 0) ? abus0 : abus1, 9'd0);
      checkOutput($sformatf("rst_rdata%0d", s), (s == 0) ? rdata0 : rdata1, '0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    phaseCheck(24);
  endtask

  // One PIO read on instance s, checked cycle by cycle against the timing model
  task automatic applyStimulus(input int s, input logic [8:0] a, input logic [WB-1:0] word,
                               input logic pbit, input bit keepReq, input bit pulseReq,
                               input int abortBit);
    int p, bt, n, b;
    int kA, k0, kS, kP, kD, k;
    bit parEn;
    logic expPerr;
`ifdef PIO_PARITY_EN
    parEn = 1'b1;
`else
    parEn = 1'b0;
`endif
    p  = (s == 0) ? 1 : 3;
    bt = 4 * p;
    n  = 0;
    while (ready[s] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (ready[s] !== 1'b1) begin
      checkOutput("ready_timeout", {31'd0, ready[s]}, 32'd1);
      return;
    end
    req[s] = 1'b1;
    setAddr(s, a);
    @(negedge clk);
    kA = cyc;
    k0 = (((kA - 1) / bt) + 1) * bt + 1;
    kS = k0 + bt;
    kP = kS + bt * WB;
    kD = kP + (parEn ? bt : 0);
    while (1) begin
      k = cyc;
      if (!keepReq) req[s] = (pulseReq && k == kA + 20);
      setAddr(s, 9'($urandom));
      datav[s] = 1'($urandom);
      if (k >= kS && k < kD && ((k - kS) % bt) == 3 * p - 1) begin
        b = (k - kS) / bt;
        datav[s] = (b < WB) ? word[WB-1-b] : pbit;
      end
      checkOutput($sformatf("piov%0d_c%0d", s, k), piov[s], (k >= k0 && k < kS));
      checkOutput($sformatf("abus%0d_c%0d", s, k), (s == 0) ? abus0 : abus1,
                  (k >= k0 && k < kS) ? a : 9'd0);
      checkOutput($sformatf("busy_ready%0d_c%0d", s, k), ready[s], 1'b0);
      checkOutput($sformatf("rvalid%0d_c%0d", s, k), rvalid[s], (k == kD));
      if (abortBit >= 0 && k == kS + abortBit * bt + 1) begin
        resetPulse();
        return;
      end
      if (k == kD) begin
        expPerr = parEn ? ~((^word) ^ pbit) : 1'b0;
        checkOutput($sformatf("rdata%0d", s), (s == 0) ? rdata0 : rdata1, word);
        checkOutput($sformatf("perr%0d", s), perr[s], expPerr);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput($sformatf("after_ready%0d", s), ready[s], 1'b1);
    checkOutput($sformatf("after_rvalid%0d", s), rvalid[s], 1'b0);
    checkOutput($sformatf("hold_rdata%0d", s), (s == 0) ? rdata0 : rdata1, word);
  endtask

  // Test sequence
  initial begin
    req   = 2'b00;
    datav = 2'b00;
    addr0 = 9'd0;
    addr1 = 9'd0;
    rst_n = 1'b1;
    #2;
    resetPulse();

    applyStimulus(0, 9'h1A5, 26'h2AAAAAA, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(0, 9'($urandom), 26'h0000001, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(0, 9'($urandom), 26'h0000001, 1'b1, 1'b0, 1'b0, -1);

    applyStimulus(0, 9'h0FF, WB'($urandom), 1'($urandom), 1'b1, 1'b0, -1);
    applyStimulus(0, 9'h100, WB'($urandom), 1'($urandom), 1'b0, 1'b1, -1);

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      applyStimulus(0, 9'($urandom), WB'($urandom), 1'($urandom), 1'b0, 1'(i % 2), -1);
    end

    applyStimulus(0, 9'h155, 26'h3FF00AA, 1'b0, 1'b0, 1'b0, 10);
    applyStimulus(0, 9'h0AA, 26'h15A5A5A, 1'b1, 1'b0, 1'b0, -1);

    applyStimulus(1, 9'h1A5, 26'h2AAAAAA, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(1, 9'($urandom), WB'($urandom), 1'($urandom), 1'b0, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lvdc_pio_initiator.md
LVDC_PIO_INITIATOR -- requirements
Module: lvdc_pio_initiator

Interface
REQ-001 Parameter PHASE_LEN, default 1: SIM_CLK cycles per timing phase; legal range 1..15.
REQ-002 Parameter WORD_BITS, default 26: serial data bits per PIO read word.
REQ-003 SIM_CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SIM_RST  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  host request to start a PIO read.
REQ-006 addr  input  9  PIO address; bit 0 drives A1V, bit 8 drives A9V.
REQ-007 ready  output  1  high only in IDLE; a request is accepted on a clock edge where req and ready are both high.
REQ-008 rdata  output  WORD_BITS  assembled read word.
REQ-009 rvalid  output  1  one-cycle pulse marking rdata valid.
REQ-010 perr  output  1  parity error flag, qualified by rvalid.
REQ-011 A1V..A9V  output  1 each  address lines to LVDA, registered.
REQ-012 PIOV  output  1  PIO strobe to LVDA, registered.
REQ-013 WDA, XDA, YDA, ZDA  output  1 each  one-hot timing phases, registered.
REQ-014 DATAV  input  1  serial read data returned by the LVDA.

Function
REQ-015 Phase generator runs freely after reset: W, X, Y, Z, W, ... Exactly one phase output is high, for PHASE_LEN cycles each.
REQ-016 One bit time is one full W..Z rotation, i.e. 4*PHASE_LEN cycles.
REQ-017 The state machine has states IDLE, SYNC, ADDR, SHIFT, PAR and DONE.
REQ-018 IDLE: ready=1, PIOV=0, A*V=0. On accept, latch addr, clear perr, enter SYNC; ready=0 from the next cycle.
REQ-019 SYNC: hold until the first cycle of the next W phase, then enter ADDR. SYNC lasts 0..4*PHASE_LEN-1 cycles.
REQ-020 ADDR: drive A*V from the latched addr and PIOV=1 for exactly one bit time (W first cycle through Z last cycle), then enter SHIFT.
REQ-021 SHIFT lasts WORD_BITS bit times. DATAV is sampled at the edge ending the last Y cycle of each bit time, MSB first; the first sample lands in rdata[WORD_BITS-1].
REQ-022 A*V and PIOV are 0 in SYNC, SHIFT, PAR and DONE.
REQ-023 After the last data bit: go to PAR if the parity feature is compiled in, otherwise go to DONE.
REQ-024 DONE lasts one cycle: rvalid=1, then IDLE.
REQ-025 rdata changes only during SHIFT and holds its value until the next accept.
REQ-026 req while ready=0 is ignored and not queued; addr changes after accept have no effect.
REQ-027 Latency, parity off: accept edge to rvalid high is SYNC + 4*PHASE_LEN*(1+WORD_BITS) + 1 cycles.
REQ-028 With defaults this latency is 109..112 cycles.
REQ-029 Back-to-back operation: req held high is accepted on the first IDLE cycle after DONE.

Reset
REQ-030 SIM_RST low asynchronously forces state IDLE and phase counter to W-pending.
REQ-031 During reset all outputs are 0 except ready=1.
REQ-032 WDA goes high on the first rising edge after SIM_RST deasserts.
REQ-033 Reset mid-transaction abandons the transaction: no rvalid is produced, and PIOV and A*V drop immediately.

Configuration
REQ-034 Macro PIO_PARITY_EN controls parity checking.
REQ-035 With PIO_PARITY_EN defined, PAR lasts one extra bit time and DATAV is sampled as in REQ-021. perr = 1 when the XOR of the data bits and the parity bit is 0 (odd parity expected). Latency grows by 4*PHASE_LEN.
REQ-036 With PIO_PARITY_EN undefined, there is no PAR state and perr is constant 0.

Verification
REQ-037 Phase check: release reset, PHASE_LEN=1 -> WDA,XDA,YDA,ZDA one-hot, repeating every 4 cycles, WDA first.
REQ-038 Read, parity off: addr=9'h1A5, DATAV pattern 26'h2AAAAAA MSB first -> during ADDR, A1V..A9V=1,0,1,0,0,1,0,1,1 and PIOV high for 4 cycles; rdata=26'h2AAAAAA; rvalid after 109..112 cycles.
REQ-039 Parity, PIO_PARITY_EN defined: data 26'h0000001 with parity bit 0 -> perr=0; same data with parity bit 1 -> perr=1.
REQ-040 Handshake: req held high continuously -> two reads, rvalid pulses one cycle each, ready low between them; a req pulse mid-transaction is ignored.
REQ-041 Reset at SHIFT bit 10 -> PIOV=0, ready=1, no rvalid; a following read returns correct data.
REQ-042 PHASE_LEN=3 -> each phase lasts 3 cycles, bit time 12 cycles, sampled data still correct.
